// File: rtl/lsu_mem_bridge_pkg.sv
// Shared encodings for the load/store bridge: SLControl codes, access sizes,
// the bridge FSM state type and small decode helpers. The control unit imports
// this same package so both sides agree on one encoding.
package lsu_pkg;

  // SLControl codes: bit 3 = store, bit 2 = unsigned load, bits 1:0 = size
  localparam logic [3:0] SL_LB   = 4'b0000;
  localparam logic [3:0] SL_LH   = 4'b0001;
  localparam logic [3:0] SL_LW   = 4'b0010;
  localparam logic [3:0] SL_LBU  = 4'b0100;
  localparam logic [3:0] SL_LHU  = 4'b0101;
  localparam logic [3:0] SL_SB   = 4'b1000;
  localparam logic [3:0] SL_SH   = 4'b1001;
  localparam logic [3:0] SL_SW   = 4'b1010;
  localparam logic [3:0] SL_NONE = 4'b1111;

  // Access size field (sl_ctrl[1:0])
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_store(input logic [3:0] code);
    return code[3];
  endfunction

  // True only for the eight real access codes (SL_NONE and reserved are false)
  function automatic logic is_valid(input logic [3:0] code);
    case (code)
      SL_LB, SL_LH, SL_LW, SL_LBU, SL_LHU, SL_SB, SL_SH, SL_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0
  function automatic logic is_misaligned(input logic [3:0] code, input logic [1:0] off);
    case (code[1:0])
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_bridge_if.sv
// Word-wide memory bus between the bridge (master) and memory/peripherals.
// Handshake: the master raises bus_req with bus_addr/bus_we/bus_be/bus_wdata
// and holds all of them stable until the slave returns bus_ack=1 for exactly
// the completing cycle; bus_rdata is only meaningful on that ack cycle. The
// master drops bus_req in the cycle after the ack and never re-raises it
// without first passing through an idle cycle.
interface lsu_mem_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [3:0]        bus_be;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/lsu_mem_bridge_lane_align.sv
// Purely combinational byte-lane logic for the bridge: store side builds byte
// enables and lane-replicated write data, load side selects the addressed lane
// of the read word and sign/zero-extends it. Halfwords use addr[1] only and
// words use lane 0 only, so low address bits that cannot matter are ignored.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [4:0]  ld_shamt;
  logic [31:0] ld_lane;

  // Store side: byte enables and replicated write data
  always_comb begin
    st_be_o   = 4'b1111;
    st_data_o = st_data_i;
    case (st_size_i)
      SZ_BYTE: begin
        st_be_o   = 4'b0001 << st_off_i;
        st_data_o = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        st_be_o   = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_data_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: shift the addressed lane down, then extend to 32 bits
  always_comb begin
    ld_shamt = 5'd0;
    case (ld_size_i)
      SZ_BYTE: ld_shamt = {ld_off_i, 3'b000};
      SZ_HALF: ld_shamt = {ld_off_i[1], 4'b0000};
      default: ;
    endcase
    ld_lane   = ld_word_i >> ld_shamt;
    ld_data_o = ld_lane;
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{ld_lane[7] & ~ld_unsigned_i}}, ld_lane[7:0]};
      SZ_HALF: ld_data_o = {{16{ld_lane[15] & ~ld_unsigned_i}}, ld_lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge: turns one core request (mreq, mem_write, sl_ctrl) into
// one word-wide req/ack bus transaction and stalls the core until DONE.
// Optional build macro: MISALIGN_TRAP_EN -- misaligned halfword/word accesses
// are not issued; the FSM goes straight to DONE and pulses misalign.
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mreq,
  input  logic               mem_write,
  input  logic [3:0]         sl_ctrl,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               stall,
  output logic               err,
  output logic               misalign,
  lsu_mem_bridge_if.master   bus,
  output lsu_state_e         dbg_state_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        ctrl_q;
  logic [3:0]        be_q;
  logic [31:0]       bwdata_q;
  logic              latch_en;
  logic              req_ok;
  logic              req_bad;
  logic              trap;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;

  lsu_lane_align u_align (
    .st_size_i     (sl_ctrl[1:0]),
    .st_off_i      (addr[1:0]),
    .st_data_i     (wdata),
    .st_be_o       (st_be),
    .st_data_o     (st_data),
    .ld_size_i     (ctrl_q[1:0]),
    .ld_unsigned_i (ctrl_q[2]),
    .ld_off_i      (addr_q[1:0]),
    .ld_word_i     (bus.bus_rdata),
    .ld_data_o     (ld_data)
  );

  // A request is taken only for a real code whose store bit agrees with mem_write
  assign req_ok  = mreq && is_valid(sl_ctrl) && (mem_write == is_store(sl_ctrl));
  assign req_bad = mreq && (sl_ctrl != SL_NONE) && !req_ok;

`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(sl_ctrl, addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // FSM state register, timeout counter and pulsed status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      misalign_q <= misalign_d;
    end
  end

  // Request capture: bus fields are frozen here for the whole transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      ctrl_q   <= 4'd0;
      be_q     <= 4'd0;
      bwdata_q <= 32'd0;
    end else if (latch_en) begin
      addr_q   <= addr;
      ctrl_q   <= sl_ctrl;
      be_q     <= st_be;
      bwdata_q <= st_data;
    end
  end

  // Next-state, stall and result logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    misalign_d = 1'b0;
    latch_en   = 1'b0;
    stall      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_ok && trap) begin
          stall      = 1'b1;
          misalign_d = 1'b1;
          rdata_d    = 32'd0;
          state_d    = ST_DONE;
        end else if (req_ok) begin
          stall    = 1'b1;
          latch_en = 1'b1;
          cnt_d    = 16'd0;
          state_d  = ST_REQ;
        end else if (req_bad) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end
      end
      ST_REQ: begin
        stall = mreq;
        if (bus.bus_ack) begin
          rdata_d = is_store(ctrl_q) ? 32'd0 : ld_data;
          state_d = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.bus_req   = (state_q == ST_REQ);
  assign bus.bus_we    = ctrl_q[3];
  assign bus.bus_be    = be_q;
  assign bus.bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.bus_wdata = bwdata_q;
  assign rdata         = rdata_q;
  assign err           = err_q;
  assign misalign      = misalign_q;
  assign dbg_state_o   = state_q;

endmodule
